pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32: PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 32'h0000_0000 (XLEN bits): PC value loaded on reset.
REQ-003 Parameter INCR, default 4: sequential PC increment in bytes.
REQ-004 Parameter ALIGN_BITS, default 2: low target bits that SHALL be zero for a legal target.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 write_en_i  in  1  PC update enable; 0 = hazard hold.
REQ-008 global_stall_i  in  1  pipeline-wide stall; 1 = hold.
REQ-009 global_flush_i  in  1  discard the pending redirect, no PC change.
REQ-010 redirect_valid_i  in  1  branch/jump redirect request.
REQ-011 redirect_target_i  in  XLEN  redirect destination.
REQ-012 trap_valid_i  in  1  trap entry request.
REQ-013 trap_vector_i  in  XLEN  trap destination.
REQ-014 halt_i  in  1  request to halt fetch.
REQ-015 pc_o  out  XLEN  current fetch PC.
REQ-016 pc_valid_o  out  1  pc_o is a fetchable address.
REQ-017 misaligned_o  out  1  one-cycle pulse: rejected misaligned target.
REQ-018 redirect_pending_o  out  1  a redirect is latched, awaiting advance.

Function
REQ-019 Define advance = write_en_i AND NOT global_stall_i.
REQ-020 States SHALL be BOOT, RUN, PENDING and HALTED; BOOT SHALL last exactly one cycle after reset release, then go to RUN, with pc_o = RESET_VECTOR and pc_valid_o = 0.
REQ-021 In RUN/PENDING, next-PC priority per edge SHALL be: trap, then halt_i, then a new redirect, then the pending redirect, then increment.
REQ-022 trap_valid_i SHALL load trap_vector_i into pc_o at the next edge regardless of advance.
REQ-023 trap_valid_i SHALL also clear any pending redirect and enter RUN, including from HALTED.
REQ-024 halt_i (without trap) SHALL enter HALTED with pc_o held and pending cleared.
REQ-025 In RUN with redirect_valid_i and advance=1, pc_o SHALL equal redirect_target_i after one edge (latency 1).
REQ-026 In RUN with redirect_valid_i and advance=0, the target SHALL be latched, the state SHALL become PENDING and pc_o SHALL be held.
REQ-027 In PENDING, a new redirect_valid_i SHALL overwrite the latched target (latest wins).
REQ-028 In PENDING, on the first edge with advance=1, pc_o SHALL take the latched (or simultaneous new) target and the state SHALL return to RUN.
REQ-029 global_flush_i without trap SHALL clear the pending redirect and return PENDING to RUN, with pc_o unchanged that edge; a redirect in the same cycle SHALL take priority over the flush.
REQ-030 With no event and advance=1, pc_o SHALL become (pc_o + INCR) mod 2^XLEN; 0xFFFF_FFFC SHALL wrap to 0x0000_0000.
REQ-031 With no event and advance=0, pc_o SHALL hold.
REQ-032 A redirect or trap target with a nonzero [ALIGN_BITS-1:0] SHALL NOT be loaded or latched; misaligned_o SHALL pulse for one cycle and the state SHALL become HALTED.
REQ-033 In HALTED, pc_valid_o SHALL be 0, pc_o SHALL hold, and only reset or a legal trap SHALL leave the state.
REQ-034 pc_valid_o SHALL be 1 in RUN and PENDING.
REQ-035 redirect_pending_o SHALL be 1 exactly in PENDING.

Reset
REQ-036 While rst_n=0 at an edge: pc_o = RESET_VECTOR, state = BOOT, pc_valid_o = 0, misaligned_o = 0, redirect_pending_o = 0, and the latched target = 0; reset mid-PENDING SHALL discard the target.

Structure
REQ-037 The state enum and default constants (XLEN, RESET_VECTOR, INCR) SHALL live in the shared package pc_pkg.
REQ-038 The pending target and its valid bit SHALL be one sub-module, pc_redirect_latch.

Verification
REQ-039 Reset with pc inputs 0xFFFF_FFFF -> pc_o=0x0, pc_valid_o=0; one cycle after release pc_valid_o=1; next edge pc_o=0x4.
REQ-040 write_en_i=0 with redirect to 0x100 -> pc_o holds, redirect_pending_o=1; write_en_i=1 -> pc_o=0x100 after one edge, pending=0.
REQ-041 Stalled redirects to 0x200 then 0x300 -> release yields pc_o=0x300; stalled redirect followed by flush -> pending=0 and pc resumes increment.
REQ-042 Trap 0x80 with redirect 0x400 during a stall -> pc_o=0x80 next edge; redirect dropped.
REQ-043 Redirect to 0x102 -> misaligned_o pulses once, pc_valid_o=0, pc_o held; then trap 0x80 -> RUN, pc_o=0x80.
REQ-044 pc_o=0xFFFF_FFFC advancing -> pc_o=0x0000_0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the PC sequencer and its pending-redirect latch.
package pc_pkg;

    localparam int unsigned XLEN_DEFAULT         = 32;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam int unsigned INCR_DEFAULT         = 4;
    localparam int unsigned ALIGN_BITS_DEFAULT   = 2;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StPending,
        StHalted
    } pc_state_e;

endpackage

// File: rtl/pc_redirect_latch.sv
// Holds a redirect target that arrived while the pipeline could not advance.
module pc_redirect_latch #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            set,
    input  logic            clr,
    input  logic [XLEN-1:0] target_in,
    output logic [XLEN-1:0] target,
    output logic            valid
);

    logic [XLEN-1:0] target_q;
    logic            valid_q;

    // A new latch request wins over a clear in the same cycle (latest redirect wins).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q <= '0;
            valid_q  <= 1'b0;
        end else if (set) begin
            target_q <= target_in;
            valid_q  <= 1'b1;
        end else if (clr) begin
            valid_q  <= 1'b0;
        end
    end

    assign target = target_q;
    assign valid  = valid_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: boot, sequential increment, redirects (immediate or deferred), traps, halt.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
    parameter int unsigned     INCR         = INCR_DEFAULT,
    parameter int unsigned     ALIGN_BITS   = ALIGN_BITS_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            write_en_i,
    input  logic            global_stall_i,
    input  logic            global_flush_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misaligned_o,
    output logic            redirect_pending_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q;
    logic            misaligned_q, misaligned_d;
    logic            lat_set, lat_clr;
    logic [XLEN-1:0] pending_target;
    logic            pending_valid;
    logic            advance;
    logic            trap_ok;
    logic            redirect_ok;

    assign advance     = write_en_i & ~global_stall_i;
    assign trap_ok     = (trap_vector_i & ALIGN_MASK) == '0;
    assign redirect_ok = (redirect_target_i & ALIGN_MASK) == '0;

    pc_redirect_latch #(
        .XLEN (XLEN)
    ) u_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .set       (lat_set),
        .clr       (lat_clr),
        .target_in (redirect_target_i),
        .target    (pending_target),
        .valid     (pending_valid)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        lat_set      = 1'b0;
        lat_clr      = 1'b0;
        unique case (state_q)
            StBoot: state_d = StRun;
            StRun, StPending: begin
                if (trap_valid_i) begin
                    lat_clr = 1'b1;
                    if (trap_ok) begin
                        pc_d    = trap_vector_i;
                        state_d = StRun;
                    end else begin
                        misaligned_d = 1'b1;
                        state_d      = StHalted;
                    end
                end else if (halt_i) begin
                    lat_clr = 1'b1;
                    state_d = StHalted;
                end else if (redirect_valid_i) begin
                    if (!redirect_ok) begin
                        lat_clr      = 1'b1;
                        misaligned_d = 1'b1;
                        state_d      = StHalted;
                    end else if (advance) begin
                        lat_clr = 1'b1;
                        pc_d    = redirect_target_i;
                        state_d = StRun;
                    end else begin
                        lat_set = 1'b1;
                        state_d = StPending;
                    end
                end else if (global_flush_i) begin
                    // Flush drops the deferred redirect but never moves the PC itself.
                    lat_clr = 1'b1;
                    state_d = StRun;
                end else if (state_q == StPending) begin
                    if (advance) begin
                        lat_clr = 1'b1;
                        pc_d    = pending_target;
                        state_d = StRun;
                    end
                end else if (advance) begin
                    pc_d = pc_q + XLEN'(INCR);
                end
            end
            StHalted: begin
                if (trap_valid_i) begin
                    if (trap_ok) begin
                        pc_d    = trap_vector_i;
                        state_d = StRun;
                    end else begin
                        misaligned_d = 1'b1;
                    end
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StBoot;
            pc_q         <= RESET_VECTOR;
            pc_valid_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pc_valid_q   <= (state_d == StRun) || (state_d == StPending);
            misaligned_q <= misaligned_d;
        end
    end

    assign pc_o               = pc_q;
    assign pc_valid_o         = pc_valid_q;
    assign misaligned_o       = misaligned_q;
    assign redirect_pending_o = pending_valid;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized bench for pc_sequencer, checked against a behavioural model every cycle.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        write_en_i;
    logic        global_stall_i;
    logic        global_flush_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        trap_valid_i;
    logic [31:0] trap_vector_i;
    logic        halt_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        misaligned_o;
    logic        redirect_pending_o;

    int total;
    int bad;

    pc_sequencer u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .write_en_i         (write_en_i),
        .global_stall_i     (global_stall_i),
        .global_flush_i     (global_flush_i),
        .redirect_valid_i   (redirect_valid_i),
        .redirect_target_i  (redirect_target_i),
        .trap_valid_i       (trap_valid_i),
        .trap_vector_i      (trap_vector_i),
        .halt_i             (halt_i),
        .pc_o               (pc_o),
        .pc_valid_o         (pc_valid_o),
        .misaligned_o       (misaligned_o),
        .redirect_pending_o (redirect_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference view of the sequencer: what the fetch PC is, whether a redirect waits,
    // whether fetch is halted, and whether we are in the one post-reset boot cycle.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pend;
        logic        halted;
        logic        boot;
        logic        mis;
    } model_t;

    model_t m;

    function automatic bit legal(input logic [31:0] t);
        return (t % 4) == 0;
    endfunction

    function automatic model_t model_next(input model_t cur);
        model_t n;
        bit     adv;
        n     = cur;
        n.mis = 1'b0;
        adv   = write_en_i && !global_stall_i;
        if (!rst_n) begin
            n.pc = 32'h0; n.tgt = 32'h0; n.pend = 1'b0; n.halted = 1'b0; n.boot = 1'b1;
        end else if (cur.boot) begin
            n.boot = 1'b0;
        end else if (cur.halted) begin
            if (trap_valid_i) begin
                if (legal(trap_vector_i)) begin
                    n.pc = trap_vector_i; n.halted = 1'b0;
                end else begin
                    n.mis = 1'b1;
                end
            end
        end else if (trap_valid_i) begin
            n.pend = 1'b0;
            if (legal(trap_vector_i)) n.pc = trap_vector_i;
            else begin n.mis = 1'b1; n.halted = 1'b1; end
        end else if (halt_i) begin
            n.pend = 1'b0; n.halted = 1'b1;
        end else if (redirect_valid_i) begin
            if (!legal(redirect_target_i)) begin
                n.mis = 1'b1; n.halted = 1'b1; n.pend = 1'b0;
            end else if (adv) begin
                n.pc = redirect_target_i; n.pend = 1'b0;
            end else begin
                n.pend = 1'b1; n.tgt = redirect_target_i;
            end
        end else if (global_flush_i) begin
            n.pend = 1'b0;
        end else if (cur.pend) begin
            if (adv) begin n.pc = cur.tgt; n.pend = 1'b0; end
        end else if (adv) begin
            n.pc = 32'((64'(cur.pc) + 64'd4) % 64'h1_0000_0000);
        end
        return n;
    endfunction

    always @(posedge clk) m <= model_next(m);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("pc", pc_o, m.pc);
        chk("pc_valid", 32'(pc_valid_o), 32'(!m.boot && !m.halted));
        chk("misaligned", 32'(misaligned_o), 32'(m.mis));
        chk("pending", 32'(redirect_pending_o), 32'(m.pend));
    endtask

    // Drive inputs just after a falling edge, let one rising edge happen, check at the next fall.
    task automatic step(input logic rst, input logic we, input logic st, input logic fl,
                        input logic rv, input logic [31:0] rt, input logic tv,
                        input logic [31:0] tvec, input logic hl);
        rst_n             = rst;
        write_en_i        = we;
        global_stall_i    = st;
        global_flush_i    = fl;
        redirect_valid_i  = rv;
        redirect_target_i = rt;
        trap_valid_i      = tv;
        trap_vector_i     = tvec;
        halt_i            = hl;
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic idle();
        step(1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        @(negedge clk);

        // Reset with everything else driven high.
        step(0, 1, 1, 1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1);
        step(0, 1, 1, 1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 1);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_valid", 32'(pc_valid_o), 32'h0);
        chk("rst_pending", 32'(redirect_pending_o), 32'h0);
        idle();
        chk("boot_valid", 32'(pc_valid_o), 32'h1);
        chk("boot_pc", pc_o, 32'h0);
        idle();
        chk("first_incr", pc_o, 32'h4);

        // Hazard hold defers the redirect.
        step(1, 0, 0, 0, 1, 32'h100, 0, 32'h0, 0);
        chk("hold_pc", pc_o, 32'h4);
        chk("hold_pending", 32'(redirect_pending_o), 32'h1);
        idle();
        chk("release_pc", pc_o, 32'h100);
        chk("release_pending", 32'(redirect_pending_o), 32'h0);

        // Latest stalled redirect wins.
        step(1, 1, 1, 0, 1, 32'h200, 0, 32'h0, 0);
        step(1, 1, 1, 0, 1, 32'h300, 0, 32'h0, 0);
        idle();
        chk("latest_wins", pc_o, 32'h300);

        // Flush discards the deferred redirect without moving the PC.
        step(1, 1, 1, 0, 1, 32'h500, 0, 32'h0, 0);
        step(1, 1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        chk("flush_pending", 32'(redirect_pending_o), 32'h0);
        chk("flush_pc", pc_o, 32'h300);
        idle();
        chk("flush_resume", pc_o, 32'h304);

        // Trap beats a redirect even while stalled.
        step(1, 1, 1, 0, 1, 32'h400, 1, 32'h80, 0);
        chk("trap_pc", pc_o, 32'h80);
        chk("trap_drop", 32'(redirect_pending_o), 32'h0);
        idle();
        chk("trap_then_incr", pc_o, 32'h84);

        // Misaligned redirect halts fetch; a legal trap recovers.
        step(1, 1, 0, 0, 1, 32'h102, 0, 32'h0, 0);
        chk("mis_pulse", 32'(misaligned_o), 32'h1);
        chk("mis_valid", 32'(pc_valid_o), 32'h0);
        chk("mis_pc", pc_o, 32'h84);
        idle();
        chk("mis_once", 32'(misaligned_o), 32'h0);
        chk("halted_pc", pc_o, 32'h84);
        step(1, 1, 0, 0, 0, 32'h0, 1, 32'h80, 0);
        chk("recover_valid", 32'(pc_valid_o), 32'h1);
        chk("recover_pc", pc_o, 32'h80);

        // Wrap at the top of the address space.
        step(1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        chk("top_pc", pc_o, 32'hFFFF_FFFC);
        idle();
        chk("wrap_pc", pc_o, 32'h0);

        // Reset while a redirect is pending forgets it.
        step(1, 0, 0, 0, 1, 32'h600, 0, 32'h0, 0);
        step(0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        chk("rst_mid_pending", 32'(redirect_pending_o), 32'h0);
        idle();
        idle();
        chk("rst_mid_pc", pc_o, 32'h4);

        // Randomized traffic, biased toward legal targets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt;
            logic [31:0] tvec;
            rt   = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            tvec = ($urandom_range(0, 7) == 0) ? $urandom() : ($urandom() & 32'h0000_FFFC);
            if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFFC;
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), rt,
                 ($urandom_range(0, 15) == 0), tvec,
                 ($urandom_range(0, 31) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
